// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_pkg: shared types and constants for the 4x3 keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 3;
    localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;
    localparam int KEY_ENTER = 10;
    localparam int KEY_NEXT  = 11;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        DEB  = 2'd1,
        HOLD = 2'd2,
        REL  = 2'd3
    } state_t;

    // One-hot key code from a one-hot row and one-hot column: bit 3*r+c.
    function automatic logic [NUM_KEYS-1:0] key_code(input logic [NUM_ROWS-1:0] r,
                                                     input logic [NUM_COLS-1:0] c);
        logic [NUM_KEYS-1:0] k;
        k = '0;
        for (int i = 0; i < NUM_ROWS; i++) k[i*NUM_COLS +: NUM_COLS] = r[i] ? c : '0;
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad lines plus the key-code output bus
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic [NUM_KEYS-1:0] scan_data;
    logic                valid;
    logic                key_down;

    modport master (input row, output col, scan_data, valid, key_down);
    modport slave (output row, input col, scan_data, valid, key_down);

endinterface

// File: rtl/keypad_scan_ctrl_sync2.sv
// sync2: two-flop synchronizer with asynchronous active-high reset
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops to settle metastability on asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scanning, debouncing 4x3 keypad controller
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scan_ctrl_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CYCLES - 1);

    logic [NUM_ROWS-1:0] rs;
    state_t              state_q;
    logic [NUM_COLS-1:0] col_q;
    logic [NUM_COLS-1:0] col_next_d;
    logic [DW-1:0]       dwell_q;
    logic [BW-1:0]       deb_q;
    logic [BW-1:0]       deb_inc_d;
    logic [NUM_ROWS-1:0] row_q;
    logic [NUM_KEYS-1:0] scan_data_q;
    logic                valid_q;
    logic                key_down_q;

    sync2 #(.W(NUM_ROWS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.row),
        .q_o (rs)
    );

    assign col_next_d = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
    assign deb_inc_d  = (deb_q == '1) ? deb_q : deb_q + 1'b1;

    // Scan/debounce/hold/release sequencer; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 3'b001;
            dwell_q     <= '0;
            deb_q       <= '0;
            row_q       <= '0;
            scan_data_q <= '0;
            valid_q     <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if ($onehot(rs)) begin
                            row_q   <= rs;
                            deb_q   <= '0;
                            state_q <= DEB;
                        end else begin
                            col_q <= col_next_d;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                DEB: begin
                    if (rs != row_q) begin
                        state_q <= SCAN;
                        col_q   <= col_next_d;
                        dwell_q <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        scan_data_q <= key_code(row_q, col_q);
                        valid_q     <= 1'b1;
                        key_down_q  <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        deb_q <= deb_inc_d;
                    end
                end
                HOLD: begin
                    if (rs == '0) begin
                        deb_q   <= '0;
                        state_q <= REL;
                    end
                end
                REL: begin
                    if (rs != '0) begin
                        state_q <= HOLD;
                    end else if (deb_q == DEB_LAST) begin
                        state_q    <= SCAN;
                        col_q      <= col_next_d;
                        dwell_q    <= '0;
                        key_down_q <= 1'b0;
                    end else begin
                        deb_q <= deb_inc_d;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.col       = col_q;
    assign kp.scan_data = scan_data_q;
    assign kp.valid     = valid_q;
    assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad model plus cycle reference for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    localparam int SD = 16;
    localparam int DC = 256;
    localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2, M_REL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pressed = '0;

    int checks = 0;
    int passed = 0;
    int nvalid = 0;

    int         m_col = 0, m_mode = M_SCAN, m_t = 0, m_row = 0;
    logic [3:0] m_s1 = '0, m_s2 = '0;
    logic [11:0] m_data = '0;
    logic       m_valid = 1'b0, m_down = 1'b0;

    keypad_scan_ctrl_if kp ();

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column while that column is driven.
    always_comb begin
        kp.row = '0;
        for (int r = 0; r < 4; r++) kp.row[r] = |(pressed[3*r +: 3] & kp.col);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [3:0] rows_hit(input logic [11:0] p, input int c);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = p[3*i + c];
        return r;
    endfunction

    task automatic model_step();
        logic [3:0] raw, rs;
        if (rst) begin
            m_col = 0; m_mode = M_SCAN; m_t = 0; m_s1 = '0; m_s2 = '0;
            m_data = '0; m_valid = 1'b0; m_down = 1'b0;
            return;
        end
        raw = rows_hit(pressed, m_col);
        rs = m_s2;
        m_valid = 1'b0;
        if (m_mode == M_SCAN) begin
            m_t++;
            if (m_t == SD) begin
                m_t = 0;
                if ($countones(rs) == 1) begin
                    m_mode = M_DEB;
                    for (int i = 0; i < 4; i++) if (rs[i]) m_row = i;
                end else m_col = (m_col + 1) % 3;
            end
        end else if (m_mode == M_DEB) begin
            if (rs != 4'(1 << m_row)) begin
                m_mode = M_SCAN; m_t = 0; m_col = (m_col + 1) % 3;
            end else begin
                m_t++;
                if (m_t == DC) begin
                    m_data = '0;
                    m_data[3*m_row + m_col] = 1'b1;
                    m_valid = 1'b1; m_down = 1'b1; m_mode = M_HOLD;
                end
            end
        end else if (m_mode == M_HOLD) begin
            if (rs == '0) begin m_mode = M_REL; m_t = 0; end
        end else begin
            if (rs != '0) m_mode = M_HOLD;
            else begin
                m_t++;
                if (m_t == DC) begin
                    m_mode = M_SCAN; m_t = 0; m_col = (m_col + 1) % 3; m_down = 1'b0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Advance the reference on each edge and compare every output just after it.
    initial forever begin
        logic [2:0] ec;
        @(posedge clk);
        model_step();
        #1;
        ec = 3'b001 << m_col;
        if (kp.valid) nvalid++;
        chk("col", 32'(kp.col), 32'(ec));
        chk("scan_data", 32'(kp.scan_data), 32'(m_data));
        chk("valid", 32'(kp.valid), 32'(m_valid));
        chk("key_down", 32'(kp.key_down), 32'(m_down));
    end

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!kp.valid && n < 1000) begin @(negedge clk); n++; end
        chk(nm, 32'(kp.valid), 32'd1);
    endtask

    task automatic wait_kd_low(input string nm);
        int n = 0;
        while (kp.key_down && n < 1000) begin @(negedge clk); n++; end
        chk(nm, 32'(kp.key_down), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(kp.col), 32'h1);
        chk("rst_data", 32'(kp.scan_data), 32'h0);
        chk("rst_valid", 32'(kp.valid), 32'h0);
        chk("rst_kd", 32'(kp.key_down), 32'h0);
        rst = 1'b0;

        pressed = 12'h020;
        wait_valid("k5_valid_seen");
        chk("k5_data", 32'(kp.scan_data), 32'h020);
        chk("k5_model_data", 32'(m_data), 32'h020);
        repeat (300) @(negedge clk);
        chk("k5_kd_held", 32'(kp.key_down), 32'h1);
        chk("k5_one_valid", 32'(nvalid), 32'd1);
        pressed = '0;
        repeat (250) @(negedge clk);
        chk("k5_kd_in_rel", 32'(kp.key_down), 32'h1);
        repeat (15) @(negedge clk);
        chk("k5_kd_low", 32'(kp.key_down), 32'h0);
        chk("k5_col_next", 32'(kp.col), 32'h1);

        pressed = 12'h800;
        wait_valid("k11_valid_seen");
        chk("k11_data", 32'(kp.scan_data), 32'h800);
        pressed = '0;
        wait_kd_low("k11_release");
        chk("k11_data_kept", 32'(kp.scan_data), 32'h800);
        pressed = 12'h001;
        wait_valid("k0_valid_seen");
        chk("k0_data", 32'(kp.scan_data), 32'h001);
        chk("two_keys_valids", 32'(nvalid), 32'd3);
        pressed = '0;
        wait_kd_low("k0_release");

        nv0 = nvalid;
        for (int i = 0; i < 20; i++) begin
            pressed = 12'h080;
            repeat (50) @(negedge clk);
            pressed = '0;
            repeat (50) @(negedge clk);
        end
        chk("bounce_no_valid", 32'(nvalid), 32'(nv0));
        chk("bounce_kd", 32'(kp.key_down), 32'h0);

        pressed = 12'h012;
        repeat (200) @(negedge clk);
        chk("multi_no_valid", 32'(nvalid), 32'(nv0));
        chk("multi_kd", 32'(kp.key_down), 32'h0);
        pressed = '0;
        repeat (5) @(negedge clk);

        pressed = 12'h008;
        wait_valid("k3_valid_seen");
        chk("k3_data", 32'(kp.scan_data), 32'h008);
        nv0 = nvalid;
        for (int i = 0; i < 3; i++) begin
            pressed = '0;
            repeat (20) @(negedge clk);
            pressed = 12'h008;
            repeat (40) @(negedge clk);
            chk("relbounce_kd", 32'(kp.key_down), 32'h1);
        end
        pressed = '0;
        wait_kd_low("k3_release");
        chk("relbounce_no_2nd_valid", 32'(nvalid), 32'(nv0));

        pressed = 12'h100;
        begin
            int n = 0;
            while (!(m_mode == M_DEB && m_t == 100) && n < 1000) begin @(negedge clk); n++; end
            chk("deb100_reached", 32'(m_t), 32'd100);
        end
        nv0 = nvalid;
        rst = 1'b1;
        pressed = '0;
        @(negedge clk);
        chk("rstmid_col", 32'(kp.col), 32'h1);
        chk("rstmid_data", 32'(kp.scan_data), 32'h0);
        chk("rstmid_kd", 32'(kp.key_down), 32'h0);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        chk("rstmid_no_valid", 32'(nvalid), 32'(nv0));
        chk("rstmid_data_after", 32'(kp.scan_data), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clock cycles each column is driven during scanning (minimum 4).
REQ-002 SHALL have parameter DEB_CYCLES, default 256: consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port row, input, 4 bits: keypad row sense lines, active-high, asynchronous to clk.
REQ-006 SHALL have port col, output, 3 bits: one-hot active-high column drive.
REQ-007 SHALL have port scan_data, output, 12 bits: one-hot code of the last accepted key; bit k = key index k.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse marking a newly accepted key.
REQ-009 SHALL have port key_down, output, 1 bit: high while an accepted key is held (state HOLD).

Function
REQ-010 SHALL define key index k = 3*r + c (r = row bit 0..3, c = col bit 0..2); index 10 = enter, index 11 = next-digit, matching the display consumer.
REQ-011 SHALL pass row through a 2-flop synchronizer; all FSM decisions use the synchronized value rs (2-cycle latency).
REQ-012 SHALL implement states SCAN, DEB, HOLD, REL.
REQ-013 SCAN: col rotates 001->010->100->001, each column held SCAN_DIV cycles by a dwell counter; rs sampled only on the last dwell cycle.
REQ-014 SCAN: if the sampled rs has exactly one bit set, latch row bit and column index, freeze col, clear the debounce counter, go to DEB; rs = 0 or multiple bits set -> continue rotating.
REQ-015 DEB: each cycle rs equals the latched row, increment the counter; any mismatch -> SCAN, resuming rotation at the next column, with no valid pulse.
REQ-016 DEB: on the cycle the counter reaches DEB_CYCLES-1 with a match, the next edge SHALL load scan_data with the one-hot code, pulse valid high for exactly one cycle, and enter HOLD.
REQ-017 HOLD: col stays frozen and key_down = 1; when rs = 0, clear the counter and go to REL; a held key never produces a second valid.
REQ-018 REL: count consecutive cycles with rs = 0; any nonzero rs -> back to HOLD; after DEB_CYCLES cycles -> SCAN at the next column, key_down = 0.
REQ-019 scan_data SHALL hold its value between valid pulses; it changes only together with valid.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter; counters saturate and never wrap.
REQ-021 Simultaneous second key during DEB/HOLD/REL: rs differs from the latched row in DEB -> abort to SCAN; in HOLD/REL, treat as still pressed.

Reset
REQ-022 On rst high, asynchronously: state = SCAN, col = 3'b001, dwell and debounce counters = 0, synchronizer flops = 0, scan_data = 0, valid = 0, key_down = 0.
REQ-023 Reset asserted mid-DEB or mid-HOLD SHALL discard the pending key with no valid pulse; operation restarts at column 0 on the first edge after release.

Structure
REQ-024 Package keypad_pkg SHALL hold the state enum, NUM_ROWS = 4, NUM_COLS = 3, KEY_ENTER = 10, KEY_NEXT = 11.
REQ-025 The synchronizer SHALL be a separate sub-module sync2 (parameterized width, asynchronous reset); all other logic is in keypad_scan_ctrl.

Verification
REQ-026 Key r1,c2 (index 5) closed steadily -> exactly one valid, scan_data = 12'h020, key_down = 1 until DEB_CYCLES cycles after release.
REQ-027 Key r3,c2 (index 11) pressed, released, then r0,c0 (index 0) pressed -> two valid pulses, scan_data = 12'h800 then 12'h001.
REQ-028 Bounce: r2,c1 toggles with 50-cycle high periods (< DEB_CYCLES) -> no valid; scan resumes at the next column.
REQ-029 Rows 0 and 1 both high on column 1 -> no valid; col keeps rotating.
REQ-030 Release bounce of 40-cycle highs during REL -> returns to HOLD, no second valid.
REQ-031 rst pulsed when the DEB counter = 100 -> valid never asserts, col = 001, scan_data = 0.
